alu_reservation_station: RTL and testbench

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

---
 rtl/alu_rs_pkg.sv | 46 ++++
 rtl/alu_rs_entry.sv | 89 ++++++++
 rtl/alu_reservation_station.sv | 201 ++++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_pkg
// Description : Shared widths, ALU opcode constants and the reservation
//               station entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_rs_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OPC_W  = 4;
    localparam int SHF_W  = 5;

    typedef enum logic [OPC_W-1:0] {
        ADD  = 4'h0,
        SUB  = 4'h1,
        AND  = 4'h2,
        OR   = 4'h3,
        XOR  = 4'h4,
        SLL  = 4'h5,
        SRL  = 4'h6,
        SRA  = 4'h7,
        SLT  = 4'h8,
        SLTU = 4'h9,
        BEQ  = 4'hA,
        BNE  = 4'hB
    } alu_op_e;

    // One station slot; the age rank lives beside it in the entry module
    // because its width depends on the station depth.
    typedef struct packed {
        logic              busy;
        logic [OPC_W-1:0]  opcode;
        logic [TAG_W-1:0]  tag;
        logic [SHF_W-1:0]  shfamt;
        logic              v1;
        logic [TAG_W-1:0]  q1;
        logic [DATA_W-1:0] op1;
        logic              v2;
        logic [TAG_W-1:0]  q2;
        logic [DATA_W-1:0] op2;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_rs_entry.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_entry
// Description : Storage for one reservation station slot: operand capture
//               from the CDB, busy/free control and the slot's age rank.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs_entry
    import alu_rs_pkg::*;
#(
    parameter int RANK_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  rs_entry_t         i_wr_data,
    input  logic [RANK_W-1:0] i_wr_rank,
    input  logic              i_clr,
    input  logic              i_age_up,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output logic              o_busy,
    output logic              o_ready,
    output logic [RANK_W-1:0] o_rank,
    output logic [OPC_W-1:0]  o_opcode,
    output logic [TAG_W-1:0]  o_tag,
    output logic [SHF_W-1:0]  o_shfamt,
    output logic [DATA_W-1:0] o_op1,
    output logic [DATA_W-1:0] o_op2
);

    rs_entry_t         r_ent;
    logic [RANK_W-1:0] r_rank;
    logic              w_wake1;
    logic              w_wake2;

    assign w_wake1 = i_cdb_valid & r_ent.busy & ~r_ent.v1 & (r_ent.q1 == i_cdb_tag);
    assign w_wake2 = i_cdb_valid & r_ent.busy & ~r_ent.v2 & (r_ent.q2 == i_cdb_tag);

    // Slot contents: a write only ever targets a free slot, so it never
    // collides with wakeup or free, which only affect a busy slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent <= '0;
        end else if (i_flush) begin
            r_ent <= '0;
        end else if (i_wr_en) begin
            r_ent <= i_wr_data;
        end else begin
            if (i_clr) begin
                r_ent.busy <= 1'b0;
            end
            if (w_wake1) begin
                r_ent.v1  <= 1'b1;
                r_ent.op1 <= i_cdb_data;
            end
            if (w_wake2) begin
                r_ent.v2  <= 1'b1;
                r_ent.op2 <= i_cdb_data;
            end
        end
    end

    // Age rank: 0 is the oldest busy slot; moves up when an older slot leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rank <= '0;
        end else if (i_flush) begin
            r_rank <= '0;
        end else if (i_wr_en) begin
            r_rank <= i_wr_rank;
        end else if (i_age_up) begin
            r_rank <= r_rank - 1'b1;
        end
    end

    assign o_busy   = r_ent.busy;
    assign o_ready  = r_ent.busy & r_ent.v1 & r_ent.v2;
    assign o_rank   = r_rank;
    assign o_opcode = r_ent.opcode;
    assign o_tag    = r_ent.tag;
    assign o_shfamt = r_ent.shfamt;
    assign o_op1    = r_ent.op1;
    assign o_op2    = r_ent.op2;

endmodule
`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : alu_reservation_station
// Description : Out-of-order ALU reservation station. Holds NUM_ENT waiting
//               instructions, captures operands from the CDB and issues the
//               oldest ready instruction into a stallable issue register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int NUM_ENT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OPC_W-1:0]  disp_opcode,
    input  logic [TAG_W-1:0]  disp_tag,
    input  logic [SHF_W-1:0]  disp_shfamt,
    input  logic              disp_v1,
    input  logic              disp_v2,
    input  logic [TAG_W-1:0]  disp_q1,
    input  logic [TAG_W-1:0]  disp_q2,
    input  logic [DATA_W-1:0] disp_op1,
    input  logic [DATA_W-1:0] disp_op2,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    output logic [OPC_W-1:0]  issue_opcode,
    output logic [DATA_W-1:0] issue_op1,
    output logic [DATA_W-1:0] issue_op2,
    output logic [SHF_W-1:0]  issue_shfamt,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              issue_stall
);

    localparam int c_IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam int c_CNT_W = $clog2(NUM_ENT + 1);

    logic [NUM_ENT-1:0] w_busy;
    logic [NUM_ENT-1:0] w_ready;
    logic [NUM_ENT-1:0] w_wr_en;
    logic [NUM_ENT-1:0] w_clr;
    logic [NUM_ENT-1:0] w_age_up;
    logic [c_IDX_W-1:0] w_rank       [NUM_ENT];
    logic [OPC_W-1:0]   w_ent_opcode [NUM_ENT];
    logic [TAG_W-1:0]   w_ent_tag    [NUM_ENT];
    logic [SHF_W-1:0]   w_ent_shfamt [NUM_ENT];
    logic [DATA_W-1:0]  w_ent_op1    [NUM_ENT];
    logic [DATA_W-1:0]  w_ent_op2    [NUM_ENT];

    rs_entry_t          w_new;
    logic               w_accept;
    logic               w_load;
    logic               w_issue_fire;
    logic               w_sel_found;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic [c_IDX_W-1:0] w_sel_rank;
    logic [c_CNT_W-1:0] w_busy_cnt;
    logic [c_IDX_W-1:0] w_new_rank;
    logic               w_byp1;
    logic               w_byp2;

    logic               r_issue_valid;
    logic [OPC_W-1:0]   r_issue_opcode;
    logic [DATA_W-1:0]  r_issue_op1;
    logic [DATA_W-1:0]  r_issue_op2;
    logic [SHF_W-1:0]   r_issue_shfamt;
    logic [TAG_W-1:0]   r_issue_tag;

    // Ready is based on registered busy bits only, so a slot freed by the
    // issue this cycle is not offered to dispatch until the next cycle.
    assign disp_ready   = ~(&w_busy);
    assign w_accept     = disp_valid & disp_ready & ~flush;
    assign w_load       = ~r_issue_valid | ~issue_stall;
    assign w_issue_fire = w_load & w_sel_found & ~flush;

    assign w_byp1 = ~disp_v1 & cdb_valid & (disp_q1 == cdb_tag);
    assign w_byp2 = ~disp_v2 & cdb_valid & (disp_q2 == cdb_tag);

    // Incoming record, with operands captured from a same-cycle CDB broadcast.
    always_comb begin
        w_new        = '0;
        w_new.busy   = 1'b1;
        w_new.opcode = disp_opcode;
        w_new.tag    = disp_tag;
        w_new.shfamt = disp_shfamt;
        w_new.v1     = disp_v1 | w_byp1;
        w_new.q1     = disp_q1;
        w_new.op1    = w_byp1 ? cdb_data : disp_op1;
        w_new.v2     = disp_v2 | w_byp2;
        w_new.q2     = disp_q2;
        w_new.op2    = w_byp2 ? cdb_data : disp_op2;
    end

    // Lowest-index free slot receives the accepted dispatch.
    always_comb begin
        logic found;
        w_wr_en = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (!w_busy[i] && !found) begin
                w_wr_en[i] = w_accept;
                found      = 1'b1;
            end
        end
    end

    // Oldest ready slot: busy ranks are unique, so the minimum is unambiguous.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_rank  = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (w_ready[i] && (!w_sel_found || (w_rank[i] < w_sel_rank))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_IDX_W'(i);
                w_sel_rank  = w_rank[i];
            end
        end
    end

    // Occupancy count; a new entry ranks behind everyone still present.
    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            w_busy_cnt = w_busy_cnt + c_CNT_W'(w_busy[i]);
        end
    end

    assign w_new_rank = c_IDX_W'(w_busy_cnt - c_CNT_W'(w_issue_fire));

    // Free the issued slot and promote every younger busy slot by one rank.
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            w_clr[i]    = w_issue_fire && (w_sel_idx == c_IDX_W'(i));
            w_age_up[i] = w_issue_fire && w_busy[i] && (w_rank[i] > w_sel_rank);
        end
    end

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
        alu_rs_entry #(
            .RANK_W (c_IDX_W)
        ) u_entry (
            .clk         (clk),
            .rst         (reset),
            .i_flush     (flush),
            .i_wr_en     (w_wr_en[g]),
            .i_wr_data   (w_new),
            .i_wr_rank   (w_new_rank),
            .i_clr       (w_clr[g]),
            .i_age_up    (w_age_up[g]),
            .i_cdb_valid (cdb_valid),
            .i_cdb_tag   (cdb_tag),
            .i_cdb_data  (cdb_data),
            .o_busy      (w_busy[g]),
            .o_ready     (w_ready[g]),
            .o_rank      (w_rank[g]),
            .o_opcode    (w_ent_opcode[g]),
            .o_tag       (w_ent_tag[g]),
            .o_shfamt    (w_ent_shfamt[g]),
            .o_op1       (w_ent_op1[g]),
            .o_op2       (w_ent_op2[g])
        );
    end

    // Issue register: reloads whenever it is empty or not stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_valid  <= 1'b0;
            r_issue_opcode <= '0;
            r_issue_op1    <= '0;
            r_issue_op2    <= '0;
            r_issue_shfamt <= '0;
            r_issue_tag    <= '0;
        end else if (flush) begin
            r_issue_valid  <= 1'b0;
        end else if (w_load) begin
            r_issue_valid <= w_sel_found;
            if (w_sel_found) begin
                r_issue_opcode <= w_ent_opcode[w_sel_idx];
                r_issue_op1    <= w_ent_op1[w_sel_idx];
                r_issue_op2    <= w_ent_op2[w_sel_idx];
                r_issue_shfamt <= w_ent_shfamt[w_sel_idx];
                r_issue_tag    <= w_ent_tag[w_sel_idx];
            end
        end
    end

    assign issue_valid  = r_issue_valid;
    assign issue_opcode = r_issue_opcode;
    assign issue_op1    = r_issue_op1;
    assign issue_op2    = r_issue_op2;
    assign issue_shfamt = r_issue_shfamt;
    assign issue_tag    = r_issue_tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_reservation_station
// Description : Self-checking bench for alu_reservation_station. A queue
//               based reference model tracks dispatch order and operand
//               state; directed scenarios add hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_reservation_station;
    import alu_rs_pkg::*;

    localparam int NE = 4;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_opcode;
    logic [4:0]  disp_tag;
    logic [4:0]  disp_shfamt;
    logic        disp_v1;
    logic        disp_v2;
    logic [4:0]  disp_q1;
    logic [4:0]  disp_q2;
    logic [31:0] disp_op1;
    logic [31:0] disp_op2;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [31:0] issue_op1;
    logic [31:0] issue_op2;
    logic [4:0]  issue_shfamt;
    logic [4:0]  issue_tag;
    logic        issue_stall;

    int n_checks = 0;
    int n_errors = 0;

    alu_reservation_station #(
        .NUM_ENT (NE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_opcode  (disp_opcode),
        .disp_tag     (disp_tag),
        .disp_shfamt  (disp_shfamt),
        .disp_v1      (disp_v1),
        .disp_v2      (disp_v2),
        .disp_q1      (disp_q1),
        .disp_q2      (disp_q2),
        .disp_op1     (disp_op1),
        .disp_op2     (disp_op2),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_op1    (issue_op1),
        .issue_op2    (issue_op2),
        .issue_shfamt (issue_shfamt),
        .issue_tag    (issue_tag),
        .issue_stall  (issue_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_busy [NE];
    logic [3:0]  m_opc  [NE];
    logic [4:0]  m_tag  [NE];
    logic [4:0]  m_shf  [NE];
    logic        m_v1   [NE];
    logic        m_v2   [NE];
    logic [4:0]  m_q1   [NE];
    logic [4:0]  m_q2   [NE];
    logic [31:0] m_d1   [NE];
    logic [31:0] m_d2   [NE];
    int          age_q  [$];   // slot indices, oldest first
    logic        m_iv;
    logic [3:0]  m_iopc;
    logic [31:0] m_iop1;
    logic [31:0] m_iop2;
    logic [4:0]  m_ishf;
    logic [4:0]  m_itag;

    task automatic model_clear();
        for (int i = 0; i < NE; i++) begin
            m_busy[i] = 1'b0;
            m_v1[i]   = 1'b0;
            m_v2[i]   = 1'b0;
        end
        age_q.delete();
        m_iv = 1'b0;
    endtask

    task automatic model_step();
        int   sel;
        int   fr;
        logic room;
        if (flush) begin
            model_clear();
            return;
        end
        room = (age_q.size() < NE);
        sel  = -1;
        foreach (age_q[k]) begin
            if (sel < 0 && m_v1[age_q[k]] && m_v2[age_q[k]]) sel = age_q[k];
        end
        fr = -1;
        for (int i = 0; i < NE; i++) begin
            if (fr < 0 && !m_busy[i]) fr = i;
        end
        if (!m_iv || !issue_stall) begin
            if (sel >= 0) begin
                m_iv   = 1'b1;
                m_iopc = m_opc[sel];
                m_iop1 = m_d1[sel];
                m_iop2 = m_d2[sel];
                m_ishf = m_shf[sel];
                m_itag = m_tag[sel];
                m_busy[sel] = 1'b0;
                for (int k = 0; k < age_q.size(); k++) begin
                    if (age_q[k] == sel) begin
                        age_q.delete(k);
                        break;
                    end
                end
            end else begin
                m_iv = 1'b0;
            end
        end
        if (cdb_valid) begin
            for (int i = 0; i < NE; i++) begin
                if (m_busy[i] && !m_v1[i] && m_q1[i] == cdb_tag) begin
                    m_v1[i] = 1'b1;
                    m_d1[i] = cdb_data;
                end
                if (m_busy[i] && !m_v2[i] && m_q2[i] == cdb_tag) begin
                    m_v2[i] = 1'b1;
                    m_d2[i] = cdb_data;
                end
            end
        end
        if (disp_valid && room) begin
            m_busy[fr] = 1'b1;
            m_opc[fr]  = disp_opcode;
            m_tag[fr]  = disp_tag;
            m_shf[fr]  = disp_shfamt;
            m_q1[fr]   = disp_q1;
            m_q2[fr]   = disp_q2;
            m_v1[fr]   = disp_v1 || (cdb_valid && disp_q1 == cdb_tag);
            m_v2[fr]   = disp_v2 || (cdb_valid && disp_q2 == cdb_tag);
            m_d1[fr]   = disp_v1 ? disp_op1 : cdb_data;
            m_d2[fr]   = disp_v2 ? disp_op2 : cdb_data;
            age_q.push_back(fr);
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("cyc_disp_ready", 32'(disp_ready), 32'(age_q.size() < NE));
                chk("cyc_issue_valid", 32'(issue_valid), 32'(m_iv));
                if (m_iv) begin
                    chk("cyc_issue_opcode", 32'(issue_opcode), 32'(m_iopc));
                    chk("cyc_issue_op1", issue_op1, m_iop1);
                    chk("cyc_issue_op2", issue_op2, m_iop2);
                    chk("cyc_issue_shfamt", 32'(issue_shfamt), 32'(m_ishf));
                    chk("cyc_issue_tag", 32'(issue_tag), 32'(m_itag));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic set_disp(input logic [3:0] opc, input logic [4:0] tag,
                            input logic v1, input logic [4:0] q1, input logic [31:0] d1,
                            input logic v2, input logic [4:0] q2, input logic [31:0] d2);
        disp_valid  = 1'b1;
        disp_opcode = opc;
        disp_tag    = tag;
        disp_shfamt = tag + 5'd1;
        disp_v1     = v1;
        disp_q1     = q1;
        disp_op1    = d1;
        disp_v2     = v2;
        disp_q2     = q2;
        disp_op2    = d2;
    endtask

    task automatic set_cdb(input logic [4:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; issue_stall = 1'b0;
        disp_valid = 1'b0; disp_opcode = '0; disp_tag = '0; disp_shfamt = '0;
        disp_v1 = 1'b0; disp_v2 = 1'b0; disp_q1 = '0; disp_q2 = '0;
        disp_op1 = '0; disp_op2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        tick(); tick();
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_issue_op1", issue_op1, 32'd0);
        chk("rst_issue_tag", 32'(issue_tag), 32'd0);
        reset = 1'b0;
        tick();
        chk("rel_disp_ready", 32'(disp_ready), 32'd1);

        // Scenario 1: ready ADD issues one edge after it is written.
        set_disp(ADD, 5'd3, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7);
        tick(); idle();
        chk("s1_not_yet", 32'(issue_valid), 32'd0);
        tick();
        chk("s1_valid", 32'(issue_valid), 32'd1);
        chk("s1_op1", issue_op1, 32'd5);
        chk("s1_op2", issue_op2, 32'd7);
        chk("s1_tag", 32'(issue_tag), 32'd3);
        chk("s1_shfamt", 32'(issue_shfamt), 32'd4);
        tick();
        chk("s1_drain", 32'(issue_valid), 32'd0);

        // Scenario 2: SUB waits for tag 9, woken two cycles after dispatch.
        set_disp(SUB, 5'd4, 1'b0, 5'd9, 32'd0, 1'b1, 5'd0, 32'd3);
        tick(); idle();
        tick();
        set_cdb(5'd9, 32'h10);
        tick(); idle();
        chk("s2_wake_edge", 32'(issue_valid), 32'd0);
        tick();
        chk("s2_valid", 32'(issue_valid), 32'd1);
        chk("s2_op1", issue_op1, 32'h10);
        chk("s2_opcode", 32'(issue_opcode), 32'(SUB));
        chk("s2_tag", 32'(issue_tag), 32'd4);

        // Scenario 3: fill, refuse, wake slot 2, then flush with a dispatch.
        for (int t = 0; t < NE; t++) begin
            set_disp(ADD, 5'(10 + t), 1'b0, 5'(20 + t), 32'd0, 1'b1, 5'd0, 32'(100 + t));
            tick();
        end
        idle();
        chk("s3_full", 32'(disp_ready), 32'd0);
        set_disp(OR, 5'd14, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2);
        tick(); idle();
        chk("s3_still_full", 32'(disp_ready), 32'd0);
        set_cdb(5'd22, 32'h22);
        tick(); idle();
        chk("s3_wait", 32'(issue_valid), 32'd0);
        tick();
        chk("s3_valid", 32'(issue_valid), 32'd1);
        chk("s3_tag", 32'(issue_tag), 32'd12);
        chk("s3_op1", issue_op1, 32'h22);
        chk("s3_op2", issue_op2, 32'd102);
        chk("s3_ready_again", 32'(disp_ready), 32'd1);
        set_disp(AND, 5'd16, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1);
        flush = 1'b1;
        tick(); idle();
        chk("s3_flush_valid", 32'(issue_valid), 32'd0);
        chk("s3_flush_ready", 32'(disp_ready), 32'd1);
        tick();
        chk("s3_flush_dropped", 32'(issue_valid), 32'd0);

        // Scenario 4: A in slot 1 is older than B in slot 0; both woken together.
        set_disp(XOR, 5'd6, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2);
        tick();
        set_disp(SLT, 5'd1, 1'b0, 5'd5, 32'd0, 1'b1, 5'd0, 32'hA);
        tick();
        chk("s4_x_tag", 32'(issue_tag), 32'd6);
        set_disp(SLTU, 5'd2, 1'b0, 5'd5, 32'd0, 1'b1, 5'd0, 32'hB);
        tick(); idle();
        set_cdb(5'd5, 32'h55);
        tick(); idle();
        tick();
        chk("s4_a_tag", 32'(issue_tag), 32'd1);
        chk("s4_a_op1", issue_op1, 32'h55);
        tick();
        chk("s4_b_tag", 32'(issue_tag), 32'd2);
        chk("s4_b_op2", issue_op2, 32'hB);
        tick();
        chk("s4_drain", 32'(issue_valid), 32'd0);

        // Scenario 5: three stalled cycles hold C; D follows on release.
        set_disp(SLL, 5'd8, 1'b1, 5'd0, 32'h80, 1'b1, 5'd0, 32'h81);
        tick();
        set_disp(SRL, 5'd9, 1'b1, 5'd0, 32'h90, 1'b1, 5'd0, 32'h91);
        tick(); idle();
        issue_stall = 1'b1;
        chk("s5_c_first", 32'(issue_tag), 32'd8);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("s5_hold_valid", 32'(issue_valid), 32'd1);
            chk("s5_hold_tag", 32'(issue_tag), 32'd8);
            chk("s5_hold_op1", issue_op1, 32'h80);
        end
        issue_stall = 1'b0;
        tick();
        chk("s5_d_tag", 32'(issue_tag), 32'd9);
        chk("s5_d_op2", issue_op2, 32'h91);
        tick();
        chk("s5_drain", 32'(issue_valid), 32'd0);

        // Scenario 6: asynchronous reset with a held issue and 3 busy slots.
        set_disp(BEQ, 5'd15, 1'b1, 5'd0, 32'hE1, 1'b1, 5'd0, 32'hE2);
        tick();
        set_disp(BNE, 5'd17, 1'b0, 5'd25, 32'd0, 1'b1, 5'd0, 32'd1);
        tick();
        set_disp(SRA, 5'd18, 1'b0, 5'd25, 32'd0, 1'b1, 5'd0, 32'd2);
        issue_stall = 1'b1;
        tick();
        set_disp(ADD, 5'd19, 1'b0, 5'd25, 32'd0, 1'b1, 5'd0, 32'd3);
        tick(); idle();
        chk("s6_pre_valid", 32'(issue_valid), 32'd1);
        chk("s6_pre_tag", 32'(issue_tag), 32'd15);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_valid", 32'(issue_valid), 32'd0);
        chk("s6_async_tag", 32'(issue_tag), 32'd0);
        chk("s6_async_ready", 32'(disp_ready), 32'd1);
        tick();
        reset = 1'b0;
        issue_stall = 1'b0;
        tick();
        chk("s6_rel_ready", 32'(disp_ready), 32'd1);
        chk("s6_rel_valid", 32'(issue_valid), 32'd0);
        set_cdb(5'd25, 32'h25);
        tick(); idle();
        tick();
        chk("s6_no_ghost", 32'(issue_valid), 32'd0);
        tick();
        #2;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
